execute_stage: RTL

- Registered execute stage wrapped around the combinational ALU.
- Accepts one decoded ALU operation per cycle from decode via a valid/ready handshake and drives the ALU.
- Captures result, destination and flags into an output register for writeback, also via valid/ready.
- Owns the architectural Z/C/N flags register, which feeds ALU carryIn, and halts on divide-by-zero until software clears the fault.

---
 rtl/execute_stage.sv | 328 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// Registered execute stage around the combinational ALU.
// Optional perf counters: define EXEC_PERF_COUNT_EN.

package exec_pkg;

  typedef logic [63:0] ulong_t;

  typedef enum logic [1:0] {
    SZ8, SZ16, SZ32, SZ64
  } sizeFlags_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_CMP,
    OP_AND, OP_OR,  OP_XOR, OP_SHL,
    OP_SHR, OP_MUL, OP_DIV
  } opcode_t;

endpackage

module exec_alu
  import exec_pkg::*;
(
  input  opcode_t    op_i,
  input  sizeFlags_t aSize_i,
  input  sizeFlags_t bSize_i,
  input  logic       aSignExtend_i,
  input  logic       bSignExtend_i,
  input  ulong_t     a_i,
  input  ulong_t     b_i,
  input  logic       carryIn_i,
  input  logic       useCarry_i,
  input  sizeFlags_t resultSize_i,
  output ulong_t     result_o,
  output logic       zero_o,
  output logic       carry_o,
  output logic       negitive_o,
  output logic       divByZero_o
);

  function automatic ulong_t ext(
    ulong_t v, sizeFlags_t s, logic sx
  );
    ulong_t r;
    case (s)
      SZ8:  r = {{56{sx & v[7]}}, v[7:0]};
      SZ16: r = {{48{sx & v[15]}}, v[15:0]};
      SZ32: r = {{32{sx & v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic ulong_t msk(sizeFlags_t s);
    ulong_t r;
    case (s)
      SZ8:  r = 64'h0000_0000_0000_00ff;
      SZ16: r = 64'h0000_0000_0000_ffff;
      SZ32: r = 64'h0000_0000_ffff_ffff;
      default: r = '1;
    endcase
    return r;
  endfunction

  // Bit just above the result width is carry/borrow.
  function automatic logic cy_bit(
    logic [64:0] v, sizeFlags_t s
  );
    logic r;
    case (s)
      SZ8:  r = v[8];
      SZ16: r = v[16];
      SZ32: r = v[32];
      default: r = v[64];
    endcase
    return r;
  endfunction

  function automatic logic sg_bit(
    ulong_t v, sizeFlags_t s
  );
    logic r;
    case (s)
      SZ8:  r = v[7];
      SZ16: r = v[15];
      SZ32: r = v[31];
      default: r = v[63];
    endcase
    return r;
  endfunction

  ulong_t      a, b, m, am, bm, raw, res;
  logic [64:0] wide;
  logic        cin, cout, dz;

  // Operand extension, operation select and result sizing.
  always_comb begin
    a    = ext(a_i, aSize_i, aSignExtend_i);
    b    = ext(b_i, bSize_i, bSignExtend_i);
    m    = msk(resultSize_i);
    am   = a & m;
    bm   = b & m;
    cin  = useCarry_i & carryIn_i;
    wide = '0;
    raw  = '0;
    cout = 1'b0;
    dz   = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        wide = {1'b0, am} + {1'b0, bm}
             + {64'd0, cin};
        raw  = wide[63:0];
        cout = cy_bit(wide, resultSize_i);
      end
      OP_SUB: begin
        wide = {1'b0, am} - {1'b0, bm}
             - {64'd0, cin};
        raw  = wide[63:0];
        cout = cy_bit(wide, resultSize_i);
      end
      OP_CMP: begin
        wide = {1'b0, am} - {1'b0, bm};
        raw  = wide[63:0];
        cout = cy_bit(wide, resultSize_i);
      end
      OP_AND: raw = a & b;
      OP_OR:  raw = a | b;
      OP_XOR: raw = a ^ b;
      OP_SHL: raw = a << b[5:0];
      OP_SHR: raw = a >> b[5:0];
      OP_MUL: raw = a * b;
      OP_DIV: begin
        if (b == '0) begin
          dz  = 1'b1;
          raw = '1;
        end else begin
          raw = a / b;
        end
      end
      default: raw = '0;
    endcase
    res = raw & m;
  end

  assign result_o    = res;
  assign zero_o      = (res == '0);
  assign carry_o     = cout;
  assign negitive_o  = sg_bit(res, resultSize_i);
  assign divByZero_o = dz;

endmodule

module execute_stage
  import exec_pkg::*;
#(
  parameter int DEST_W = 5
`ifdef EXEC_PERF_COUNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  opcode_t           in_op,
  input  sizeFlags_t        in_aSize,
  input  sizeFlags_t        in_bSize,
  input  logic              in_aSignExtend,
  input  logic              in_bSignExtend,
  input  ulong_t            in_a,
  input  ulong_t            in_b,
  input  logic              in_useCarry,
  input  sizeFlags_t        in_resultSize,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_setFlags,
  output logic              out_valid,
  input  logic              out_ready,
  output ulong_t            out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_write,
  output logic              out_fault,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              flag_negitive,
  output logic              halted,
  input  logic              fault_clear
`ifdef EXEC_PERF_COUNT_EN
  , output logic [CNT_W-1:0] perf_retired
  , output logic [CNT_W-1:0] perf_stall
`endif
);

  typedef enum logic {
    S_RUN, S_HALTED
  } state_t;

  state_t            state_q;
  logic              halted_q;
  logic              valid_q, valid_d;
  ulong_t            res_q, res_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic              wr_q, wr_d;
  logic              flt_q, flt_d;
  logic [2:0]        flags_q, flags_d;

  ulong_t alu_res;
  logic   alu_z, alu_c, alu_n, alu_dz;
  logic   accept;

  exec_alu u_alu (
    .op_i          (in_op),
    .aSize_i       (in_aSize),
    .bSize_i       (in_bSize),
    .aSignExtend_i (in_aSignExtend),
    .bSignExtend_i (in_bSignExtend),
    .a_i           (in_a),
    .b_i           (in_b),
    .carryIn_i     (flags_q[1]),
    .useCarry_i    (in_useCarry),
    .resultSize_i  (in_resultSize),
    .result_o      (alu_res),
    .zero_o        (alu_z),
    .carry_o       (alu_c),
    .negitive_o    (alu_n),
    .divByZero_o   (alu_dz)
  );

  assign in_ready = (state_q == S_RUN)
                 && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Output register load/hold/drain and flag update.
  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    dest_d  = dest_q;
    wr_d    = wr_q;
    flt_d   = flt_q;
    flags_d = flags_q;
    if (accept) begin
      valid_d = 1'b1;
      res_d   = alu_res;
      dest_d  = in_dest;
      wr_d    = (in_op != OP_NOP) && !alu_dz;
      flt_d   = alu_dz;
      if (in_setFlags && !alu_dz)
        flags_d = {alu_z, alu_c, alu_n};
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Register the output stage and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      dest_q  <= '0;
      wr_q    <= 1'b0;
      flt_q   <= 1'b0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      dest_q  <= dest_d;
      wr_q    <= wr_d;
      flt_q   <= flt_d;
      flags_q <= flags_d;
    end
  end

  // Halt on a divide-by-zero until software clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (accept && alu_dz) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end
        end
        S_HALTED: begin
          if (fault_clear) begin
            state_q  <= S_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid     = valid_q;
  assign out_result    = res_q;
  assign out_dest      = dest_q;
  assign out_write     = wr_q;
  assign out_fault     = flt_q;
  assign flag_zero     = flags_q[2];
  assign flag_carry    = flags_q[1];
  assign flag_negitive = flags_q[0];
  assign halted        = halted_q;

`ifdef EXEC_PERF_COUNT_EN
  logic [CNT_W-1:0] ret_q, stall_q;

  // Count retirements and stalled decode cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_q   <= '0;
      stall_q <= '0;
    end else begin
      if (valid_q && out_ready)
        ret_q <= ret_q + 1'b1;
      if (in_valid && !in_ready)
        stall_q <= stall_q + 1'b1;
    end
  end

  assign perf_retired = ret_q;
  assign perf_stall   = stall_q;
`endif

endmodule
